// File: rtl/ttt_host_pkg.sv
// Shared definitions for the TTT host driver: opcodes, status byte layout,
// FSM states and error flag positions.
package ttt_host_pkg;

    typedef enum logic [3:0] {
        OP_NOP       = 4'b0000,
        OP_INPUT     = 4'b0001,
        OP_ADVANCE   = 4'b0010,
        OP_PROG_DUR  = 4'b1001,
        OP_PROG_GOOD = 4'b1010,
        OP_PROG_BAD  = 4'b1011,
        OP_W_GOOD    = 4'b1100,
        OP_W_BAD     = 4'b1101,
        OP_INDPTR    = 4'b1110,
        OP_INDICES   = 4'b1111
    } op_e;

    // Status byte layout: {proc[7:4], startstop[3:2], stage[1:0]}
    localparam int STAT_STAGE_LSB = 0;
    localparam int STAT_SS_LSB    = 2;
    localparam int STAT_PROC_LSB  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT_LEAVE,
        ST_WAIT_RETURN
    } state_e;

    // Bit positions inside err_flags = {timeout, overflow, illegal_op}
    localparam int ERR_ILLEGAL  = 0;
    localparam int ERR_OVERFLOW = 1;
    localparam int ERR_TIMEOUT  = 2;

    // Reserved codes the core does not understand: 0011, 01xx, 1000
    function automatic logic op_is_illegal(input logic [3:0] op);
        return (op == 4'b0011) || (op[3:2] == 2'b01) || (op == 4'b1000);
    endfunction

    // Codes that are actually presented to the core (NOP and reserved are not)
    function automatic logic op_is_driven(input logic [3:0] op);
        return (op != OP_NOP) && !op_is_illegal(op);
    endfunction

endpackage

// File: rtl/ttt_host_evt_fifo.sv
// Event FIFO: wrap-around read/write pointers plus an occupancy count.
// A push into a full FIFO is dropped unless a pop happens the same cycle.
module ttt_host_evt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop, full;

    // Work out which side of the handshake really happens and the next pointers
    always_comb begin
        full     = (cnt_q == CW'(DEPTH));
        do_pop   = pop && (cnt_q != '0);
        do_push  = push && (!full || do_pop);
        dropped  = push && full && !do_pop;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset; only slots covered by the count are ever read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign head  = mem[rd_ptr_q];
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/ttt_host_driver.sv
// Host-side driver for the TTT core: accepts commands, drives them as packets
// onto the core inputs, waits on the stage handshake for ADVANCE, and records
// start/stop events. Optional event FIFO is enabled by TTT_HOST_EVT_FIFO_EN.
module ttt_host_driver
    import ttt_host_pkg::*;
#(
    parameter int HOLD_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int EVT_DEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_op,
    input  logic [11:0] cmd_data,
    output logic [3:0]  pkt_op,
    output logic [11:0] pkt_data,
    input  logic [7:0]  status_in,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [3:0]  evt_proc,
    output logic [1:0]  evt_startstop,
    output logic        busy,
    output logic [2:0]  err_flags,
    input  logic        err_clear
);
    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);
    localparam logic [7:0] TO_LAST   = 8'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  pkt_op_q, pkt_op_d;
    logic [11:0] pkt_data_q, pkt_data_d;
    logic [3:0]  hold_cnt_q, hold_cnt_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic [2:0]  err_q, err_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        busy_q, busy_d;
    logic        set_timeout, set_illegal, set_overflow;
    logic [1:0]  stage;

    assign stage = status_in[STAT_STAGE_LSB +: 2];

`ifdef TTT_HOST_EVT_FIFO_EN
    logic       evt_push, evt_empty, evt_dropped;
    logic [5:0] evt_head;

    assign evt_push = (status_in[STAT_SS_LSB +: 2] != 2'b00);

    ttt_host_evt_fifo #(
        .DEPTH (EVT_DEPTH),
        .WIDTH (6)
    ) u_evt_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (evt_push),
        .push_data ({status_in[STAT_PROC_LSB +: 4], status_in[STAT_SS_LSB +: 2]}),
        .pop       (evt_ready),
        .head      (evt_head),
        .empty     (evt_empty),
        .dropped   (evt_dropped)
    );

    assign evt_valid     = !evt_empty;
    assign evt_proc      = evt_head[5:2];
    assign evt_startstop = evt_head[1:0];
    assign set_overflow  = evt_dropped;
`else
    logic unused_evt_inputs;

    assign unused_evt_inputs = ^{evt_ready, status_in[7:2]};
    assign evt_valid         = 1'b0;
    assign evt_proc          = 4'h0;
    assign evt_startstop     = 2'b00;
    assign set_overflow      = 1'b0;
`endif

    // Next-state logic for the command FSM, packet outputs and sticky errors
    always_comb begin
        state_d     = state_q;
        pkt_op_d    = pkt_op_q;
        pkt_data_d  = pkt_data_q;
        hold_cnt_d  = hold_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        set_timeout = 1'b0;
        set_illegal = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d     = ST_DRIVE;
                    hold_cnt_d  = '0;
                    set_illegal = op_is_illegal(cmd_op);
                    if (op_is_driven(cmd_op)) begin
                        pkt_op_d   = cmd_op;
                        pkt_data_d = cmd_data;
                    end else begin
                        pkt_op_d   = OP_NOP;
                        pkt_data_d = '0;
                    end
                end
            end
            ST_DRIVE: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    pkt_op_d   = OP_NOP;
                    pkt_data_d = '0;
                    wait_cnt_d = '0;
                    state_d    = (pkt_op_q == OP_ADVANCE) ? ST_WAIT_LEAVE : ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end
            ST_WAIT_LEAVE, ST_WAIT_RETURN: begin
                wait_cnt_d = wait_cnt_q + 8'd1;
                if (state_q == ST_WAIT_LEAVE && stage != 2'b00) begin
                    state_d = ST_WAIT_RETURN;
                end else if (state_q == ST_WAIT_RETURN && stage == 2'b00) begin
                    state_d = ST_IDLE;
                end else if (wait_cnt_q == TO_LAST) begin
                    state_d     = ST_IDLE;
                    set_timeout = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);

        err_d = err_clear ? 3'b000 : err_q;
        err_d[ERR_TIMEOUT]  = err_d[ERR_TIMEOUT]  | set_timeout;
        err_d[ERR_OVERFLOW] = err_d[ERR_OVERFLOW] | set_overflow;
        err_d[ERR_ILLEGAL]  = err_d[ERR_ILLEGAL]  | set_illegal;
    end

    // Register state, counters and all outputs; reset aborts any in-flight command
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            pkt_op_q    <= '0;
            pkt_data_q  <= '0;
            hold_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            err_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_op_q    <= pkt_op_d;
            pkt_data_q  <= pkt_data_d;
            hold_cnt_q  <= hold_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign pkt_op    = pkt_op_q;
    assign pkt_data  = pkt_data_q;
    assign err_flags = err_q;
    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_ttt_host_driver.sv
// Directed testbench for ttt_host_driver (HOLD_CYCLES=2, TIMEOUT_CYCLES=8,
// EVT_DEPTH=4). FIFO checks follow TTT_HOST_EVT_FIFO_EN.
module tb_ttt_host_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [11:0] cmd_data;
    logic [3:0]  pkt_op;
    logic [11:0] pkt_data;
    logic [7:0]  status_in;
    logic        evt_valid;
    logic        evt_ready;
    logic [3:0]  evt_proc;
    logic [1:0]  evt_startstop;
    logic        busy;
    logic [2:0]  err_flags;
    logic        err_clear;

    int total = 0;
    int bad   = 0;

    ttt_host_driver #(
        .HOLD_CYCLES    (2),
        .TIMEOUT_CYCLES (8),
        .EVT_DEPTH      (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_data      (cmd_data),
        .pkt_op        (pkt_op),
        .pkt_data      (pkt_data),
        .status_in     (status_in),
        .evt_valid     (evt_valid),
        .evt_ready     (evt_ready),
        .evt_proc      (evt_proc),
        .evt_startstop (evt_startstop),
        .busy          (busy),
        .err_flags     (err_flags),
        .err_clear     (err_clear)
    );

    // Free-running clock, 10 time units per cycle
    always #5 clk = ~clk;

    // Move to just after the next rising edge, where outputs are stable
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] op,
                                 input logic [11:0] data, input logic [7:0] status,
                                 input logic ready, input logic clear);
        cmd_valid = valid;
        cmd_op    = op;
        cmd_data  = data;
        status_in = status;
        evt_ready = ready;
        err_clear = clear;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Directed sequence: every expected value below is worked out by hand
    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 4'h0, 12'h000, 8'h00, 1'b0, 1'b0);
        tick(2);
        rst_n = 1'b1;
        checkOutput("rst_cmd_ready", 16'(cmd_ready), 16'h1);
        checkOutput("rst_busy",      16'(busy),      16'h0);
        checkOutput("rst_pkt_op",    16'(pkt_op),    16'h0);
        checkOutput("rst_pkt_data",  16'(pkt_data),  16'h0);
        checkOutput("rst_err",       16'(err_flags), 16'h0);
        checkOutput("rst_evt_valid", 16'(evt_valid), 16'h0);

        // PROG_DUR held for two cycles, then a no-op with cmd_ready back
        applyStimulus(1'b1, 4'b1001, 12'h3A5, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 12'h000, 8'h00, 1'b0, 1'b0);
        checkOutput("hold1_op",    16'(pkt_op),    16'h9);
        checkOutput("hold1_data",  16'(pkt_data),  16'h3A5);
        checkOutput("hold1_ready", 16'(cmd_ready), 16'h0);
        checkOutput("hold1_busy",  16'(busy),      16'h1);
        tick();
        checkOutput("hold2_op",    16'(pkt_op),    16'h9);
        checkOutput("hold2_data",  16'(pkt_data),  16'h3A5);
        tick();
        checkOutput("hold3_op",    16'(pkt_op),    16'h0);
        checkOutput("hold3_data",  16'(pkt_data),  16'h0);
        checkOutput("hold3_ready", 16'(cmd_ready), 16'h1);
        checkOutput("hold3_busy",  16'(busy),      16'h0);

        // ADVANCE with the full stage handshake 00,01,10,11,00
        applyStimulus(1'b1, 4'b0010, 12'h055, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 12'h000, 8'h00, 1'b0, 1'b0);
        checkOutput("adv_op", 16'(pkt_op), 16'h2);
        tick(2);
        checkOutput("adv_wait_busy", 16'(busy),   16'h1);
        checkOutput("adv_wait_op",   16'(pkt_op), 16'h0);
        status_in = 8'h01;
        tick();
        checkOutput("adv_st01_busy", 16'(busy), 16'h1);
        status_in = 8'h02;
        tick();
        checkOutput("adv_st10_busy", 16'(busy), 16'h1);
        status_in = 8'h03;
        tick();
        checkOutput("adv_st11_busy", 16'(busy), 16'h1);
        status_in = 8'h00;
        tick();
        checkOutput("adv_done_busy",  16'(busy),      16'h0);
        checkOutput("adv_done_ready", 16'(cmd_ready), 16'h1);
        checkOutput("adv_no_err",     16'(err_flags), 16'h0);
        applyStimulus(1'b1, 4'b0001, 12'h123, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 12'h000, 8'h00, 1'b0, 1'b0);
        checkOutput("next_op",   16'(pkt_op),   16'h1);
        checkOutput("next_data", 16'(pkt_data), 16'h123);
        tick(2);

        // ADVANCE with the stage stuck at 00: timeout after 8 wait cycles
        applyStimulus(1'b1, 4'b0010, 12'h000, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 12'h000, 8'h00, 1'b0, 1'b0);
        tick(2);
        tick(7);
        checkOutput("to_wait7_busy", 16'(busy),      16'h1);
        checkOutput("to_wait7_err",  16'(err_flags), 16'h0);
        tick();
        checkOutput("to_busy", 16'(busy),      16'h0);
        checkOutput("to_err",  16'(err_flags), 16'h4);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checkOutput("to_clear", 16'(err_flags), 16'h0);

        // NOP with a payload: driven as zero and raises nothing
        applyStimulus(1'b1, 4'b0000, 12'hFFF, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 12'h000, 8'h00, 1'b0, 1'b0);
        checkOutput("nop_data", 16'(pkt_data),  16'h0);
        checkOutput("nop_err",  16'(err_flags), 16'h0);
        tick(2);

        // Reserved op with err_clear in the same cycle: the new error wins
        applyStimulus(1'b1, 4'b0110, 12'hABC, 8'h00, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'h0, 12'h000, 8'h00, 1'b0, 1'b0);
        checkOutput("ill_op",   16'(pkt_op),    16'h0);
        checkOutput("ill_data", 16'(pkt_data),  16'h0);
        checkOutput("ill_err",  16'(err_flags), 16'h1);
        tick(2);

        // Reset in the middle of driving W_GOOD
        applyStimulus(1'b1, 4'b1100, 12'h777, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 4'h0, 12'h000, 8'h00, 1'b0, 1'b0);
        checkOutput("wg_op", 16'(pkt_op), 16'hC);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("mid_rst_op",    16'(pkt_op),    16'h0);
        checkOutput("mid_rst_err",   16'(err_flags), 16'h0);
        checkOutput("mid_rst_busy",  16'(busy),      16'h0);
        checkOutput("mid_rst_ready", 16'(cmd_ready), 16'h1);

`ifdef TTT_HOST_EVT_FIFO_EN
        // Five events into a four-deep FIFO: the fifth is dropped
        status_in = 8'h14; tick();
        checkOutput("evt_first_valid", 16'(evt_valid), 16'h1);
        status_in = 8'h28; tick();
        status_in = 8'h3C; tick();
        status_in = 8'h04; tick();
        checkOutput("evt_full_err", 16'(err_flags), 16'h0);
        status_in = 8'h18; tick();
        status_in = 8'h00;
        checkOutput("evt_ovf_err", 16'(err_flags), 16'h2);
        checkOutput("evt0", {10'h0, evt_proc, evt_startstop}, {10'h0, 4'h1, 2'b01});
        tick();
        checkOutput("evt0_stable", {10'h0, evt_proc, evt_startstop}, {10'h0, 4'h1, 2'b01});
        evt_ready = 1'b1;
        tick();
        checkOutput("evt1", {10'h0, evt_proc, evt_startstop}, {10'h0, 4'h2, 2'b10});
        tick();
        checkOutput("evt2", {10'h0, evt_proc, evt_startstop}, {10'h0, 4'h3, 2'b11});
        tick();
        checkOutput("evt3", {10'h0, evt_proc, evt_startstop}, {10'h0, 4'h0, 2'b01});
        tick();
        checkOutput("evt_empty", 16'(evt_valid), 16'h0);
        tick();
        checkOutput("evt_pop_empty", 16'(evt_valid), 16'h0);
        evt_ready = 1'b0;
`else
        // Without the FIFO, events are never reported and never overflow
        status_in = 8'h1C;
        tick(6);
        checkOutput("nofifo_valid", 16'(evt_valid), 16'h0);
        checkOutput("nofifo_proc",  16'(evt_proc),  16'h0);
        checkOutput("nofifo_err",   16'(err_flags), 16'h0);
        status_in = 8'h00;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ttt_host_driver.md
TTT_HOST_DRIVER -- requirements
Module: ttt_host_driver

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 1: cycles each accepted packet is driven (range 1..15).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255: max cycles spent waiting on stage handshake (8-bit counter).
REQ-003 SHALL have parameter EVT_DEPTH, default 4: event FIFO entries (power of two).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 cmd_valid  in  1  host command present.
REQ-007 cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready.
REQ-008 cmd_op  in  4  instruction code.
REQ-009 cmd_data  in  12  instruction payload.
REQ-010 pkt_op  out  4  drives core instruction nibble (ui_in[7:4]).
REQ-011 pkt_data  out  12  drives {ui_in[3:0], uio_in}.
REQ-012 status_in  in  8  core status byte {proc[7:4], startstop[3:2], stage[1:0]}.
REQ-013 evt_valid / evt_ready  out/in  1/1  event FIFO read handshake.
REQ-014 evt_proc  out  4  processor ID of head event.
REQ-015 evt_startstop  out  2  start/stop bits of head event.
REQ-016 busy  out  1  high in any state except IDLE.
REQ-017 err_flags  out  3  sticky {timeout, overflow, illegal_op}.
REQ-018 err_clear  in  1  clears err_flags next edge.

Function
REQ-019 FSM states: IDLE, DRIVE, WAIT_LEAVE, WAIT_RETURN.
REQ-020 IDLE: cmd_ready=1; pkt_op=0000, pkt_data=0 (no-op).
REQ-021 Accept at edge N registers op/data; pkt_op/pkt_data show them from cycle N+1 for exactly HOLD_CYCLES cycles (DRIVE); cmd_ready=0 outside IDLE.
REQ-022 After DRIVE: op 0010 -> WAIT_LEAVE; any other op -> IDLE (one no-op cycle guaranteed between packets).
REQ-023 WAIT_LEAVE exits to WAIT_RETURN when sampled status_in[1:0]!=00; WAIT_RETURN exits to IDLE when status_in[1:0]==00.
REQ-024 Timeout counter clears on entering WAIT_LEAVE, increments each wait cycle; reaching TIMEOUT_CYCLES -> IDLE and set timeout flag.
REQ-025 Reserved ops (0000 payload ignored; 0011, 01xx, 1000) accepted but driven as no-op; 0011/01xx/1000 set illegal_op flag; 0000 sets nothing.
REQ-026 Event push: every cycle with status_in[3:2]!=00 pushes {status_in[7:4], status_in[3:2]}, independent of FSM state.
REQ-027 FIFO full and push without pop: event dropped, overflow flag set; push and pop same cycle when full: both succeed, no overflow.
REQ-028 Pop when empty ignored; evt_valid=!empty; head data stable while evt_valid&&!evt_ready.
REQ-029 err_clear concurrent with a new error: error wins (flag stays set).

Reset
REQ-030 rst_n low at edge: FSM->IDLE, counters 0, FIFO empty, err_flags=000, pkt_op=0000, pkt_data=0, evt_valid=0, busy=0, cmd_ready=1 from the first cycle after reset.
REQ-031 Reset mid-DRIVE or mid-wait aborts the command without setting any flag; the in-flight command is lost.

Configuration
REQ-032 Macro TTT_HOST_EVT_FIFO_EN: defined -> event FIFO per REQ-026..028; undefined -> no FIFO storage, evt_valid=0, evt_proc=0, evt_startstop=0, overflow flag constant 0.

Structure
REQ-033 Package ttt_host_pkg SHALL hold the opcode enum (NOP 0000, INPUT 0001, ADVANCE 0010, PROG_DUR 1001, PROG_GOOD 1010, PROG_BAD 1011, W_GOOD 1100, W_BAD 1101, INDPTR 1110, INDICES 1111), status field bit positions, and the FSM state typedef.
REQ-034 Event FIFO SHALL be sub-module ttt_host_evt_fifo (6-bit wide, EVT_DEPTH deep, wrap-around pointers plus count).

Verification
REQ-035 HOLD_CYCLES=2, cmd op=1001 data=0x3A5 accepted at N -> pkt_op=1001, pkt_data=0x3A5 at N+1,N+2; 0000 at N+3; cmd_ready high again at N+3.
REQ-036 op=0010, status stage sequence 00,01,10,11,00 -> busy until first 00 after non-00; next command accepted the cycle after.
REQ-037 op=0010, stage held 00, TIMEOUT_CYCLES=8 -> IDLE after 8 wait cycles, err_flags=100; err_clear -> 000.
REQ-038 5 events (status 0x14,0x28,0x3C,0x04,0x18) with evt_ready=0, EVT_DEPTH=4 -> first 4 retained in order, overflow set; then pop yields proc 1/ss 01, proc 2/ss 10, ...
REQ-039 op=0110 -> pkt_op stays 0000, illegal_op set; reset asserted during DRIVE of op 1100 -> pkt_op 0000 next cycle, flags 000.
REQ-040 Build without TTT_HOST_EVT_FIFO_EN, status 0x1C -> evt_valid stays 0, overflow stays 0.
